id_hazard_fwd_unit: RTL and testbench

- Decode-stage hazard and forwarding controller. Closes the loop on the ID→EXE pipeline register: it takes that register's EXE-side outputs (ewreg, em2reg, destination register) back into ID.
- Keeps an internal EXE→MEM shadow of the destination information.
- Drives the forwarding selects for the qa/qb muxes, the PC / IF-ID write enable, and the bubble request into the ID/EXE register.
- Holds saturating performance counters for stalls and forwards.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/id_hazard_fwd_unit_sat_counter.sv | 28 ++
 rtl/id_hazard_fwd_unit.sv | 100 ++++++++++
 tb/tb_id_hazard_fwd_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode-stage definitions: forward-select encoding and register-0 constant.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXE     = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    localparam logic [4:0] REG_ZERO    = 5'd0;

    // Forward select for one source operand. An EXE-stage load never forwards
    // (its data is not ready yet), so that case falls through to the MEM check.
    function automatic logic [1:0] fwd_select(
        input logic       use_src,
        input logic [4:0] src,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_rn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && (src != REG_ZERO)) begin
            if (e_wreg && !e_m2reg && (e_rn == src)) begin
                sel = FWD_EXE;
            end else if (m_wreg && (m_rn == src)) begin
                sel = m_m2reg ? FWD_MEM_LD : FWD_MEM_ALU;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_hazard_fwd_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Latency: count reflects inc one clock after it is sampled.
// Backpressure: none; inc is accepted every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Count up on inc, holding at the all-ones ceiling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/id_hazard_fwd_unit.sv
// Decode-stage hazard/forwarding control: qa/qb forward selects, PC/IF-ID hold, ID/EXE bubble.
// Latency: all control outputs are combinational (0-cycle) from inputs and the EXE->MEM shadow.
// Backpressure: a load-use hazard holds PC and IF/ID (wpcir=0) for LOAD_STALL_CYCLES cycles.
module id_hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             flush,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    // The hz cycle itself is the first held cycle, so the counter covers the rest.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    logic       r_mwreg;
    logic       r_mm2reg;
    logic [4:0] r_mrn;
    logic [2:0] r_scnt;

    logic       w_hz;
    logic       w_stall;
    logic [1:0] w_fwda;
    logic [1:0] w_fwdb;
    logic       w_stall_inc;
    logic       w_fwd_inc;

    // EXE->MEM shadow of the destination info; this stage never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mwreg  <= 1'b0;
            r_mm2reg <= 1'b0;
            r_mrn    <= REG_ZERO;
        end else begin
            r_mwreg  <= ewreg;
            r_mm2reg <= em2reg;
            r_mrn    <= ern;
        end
    end

    // Load-use detection and forward selects from the EXE outputs and MEM shadow.
    always_comb begin
        w_hz = ewreg && em2reg && (ern != REG_ZERO) &&
               ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
        w_fwda = fwd_select(use_rs, rs, ewreg, em2reg, ern, r_mwreg, r_mm2reg, r_mrn);
        w_fwdb = fwd_select(use_rt, rt, ewreg, em2reg, ern, r_mwreg, r_mm2reg, r_mrn);
        w_stall = w_hz || (r_scnt != 3'd0);
    end

    // Remaining extra hold cycles; a flush squashes the hazard and any pending hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_scnt <= 3'd0;
        end else if (r_scnt != 3'd0) begin
            r_scnt <= r_scnt - 3'd1;
        end else if (w_hz) begin
            r_scnt <= STALL_RELOAD;
        end
    end

    // Output drive; reset forces a quiet, free-running pipeline.
    always_comb begin
        fwda   = rst ? FWD_RF : w_fwda;
        fwdb   = rst ? FWD_RF : w_fwdb;
        wpcir  = rst || flush || !w_stall;
        bubble = !rst && (w_stall || flush);
        w_stall_inc = !wpcir;
        w_fwd_inc   = ((fwda != FWD_RF) || (fwdb != FWD_RF)) && !w_stall;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fwd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_fwd_inc),
        .count (fwd_cnt)
    );

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Bench for id_hazard_fwd_unit: two instances (1-cycle stall / 32-bit counters and
// 3-cycle stall / 4-bit counters) share the inputs; directed steps then random traffic,
// each cycle compared against a cycle-indexed behavioural model.
module tb_id_hazard_fwd_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs, rt, ern;
    logic       use_rs, use_rt, ewreg, em2reg, flush;

    logic [1:0]  fwda_a, fwdb_a, fwda_b, fwdb_b;
    logic        wpcir_a, bubble_a, wpcir_b, bubble_b;
    logic [31:0] stall_cnt_a, fwd_cnt_a;
    logic [3:0]  stall_cnt_b, fwd_cnt_b;

    id_hazard_fwd_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .flush(flush),
        .fwda(fwda_a), .fwdb(fwdb_a), .wpcir(wpcir_a), .bubble(bubble_a),
        .stall_cnt(stall_cnt_a), .fwd_cnt(fwd_cnt_a)
    );

    id_hazard_fwd_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .flush(flush),
        .fwda(fwda_b), .fwdb(fwdb_b), .wpcir(wpcir_b), .bubble(bubble_b),
        .stall_cnt(stall_cnt_b), .fwd_cnt(fwd_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: previous cycle's EXE info, cycle index at which a
    // hold ends (exclusive), and plain integer counters.
    logic       m_wreg, m_m2reg;
    logic [4:0] m_rn;
    int         cyc = 0;
    int         LSC[2] = '{1, 3};
    int         CW[2]  = '{32, 4};
    int         stall_end[2] = '{0, 0};
    longint     m_sc[2] = '{0, 0};
    longint     m_fc[2] = '{0, 0};
    bit         cnt_valid = 0;

    logic       e_hz;
    logic [1:0] e_fa, e_fb;
    logic       e_stall[2];
    logic       e_wpcir[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] s, input logic u);
        if (!u || s == 5'd0) return 2'd0;
        if (ewreg && !em2reg && ern == s) return 2'd1;
        if (m_wreg && m_rn == s) return m_m2reg ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic clr();
        rst = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0;
        ewreg = 0; em2reg = 0; ern = 0; flush = 0;
    endtask

    // Compare every output of both instances against the model at the falling edge.
    task automatic settle();
        @(negedge clk);
        e_hz = ewreg && em2reg && ern != 5'd0 &&
               ((use_rs && ern == rs) || (use_rt && ern == rt));
        e_fa = rst ? 2'd0 : ref_fwd(rs, use_rs);
        e_fb = rst ? 2'd0 : ref_fwd(rt, use_rt);
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = e_hz || (cyc < stall_end[k]);
            e_wpcir[k] = rst || flush || !e_stall[k];
            chk(k == 0 ? "fwda_a" : "fwda_b", {62'd0, (k == 0 ? fwda_a : fwda_b)}, {62'd0, e_fa});
            chk(k == 0 ? "fwdb_a" : "fwdb_b", {62'd0, (k == 0 ? fwdb_a : fwdb_b)}, {62'd0, e_fb});
            chk(k == 0 ? "wpcir_a" : "wpcir_b", {63'd0, (k == 0 ? wpcir_a : wpcir_b)}, {63'd0, e_wpcir[k]});
            chk(k == 0 ? "bubble_a" : "bubble_b", {63'd0, (k == 0 ? bubble_a : bubble_b)},
                {63'd0, (!rst && (e_stall[k] || flush))});
            if (cnt_valid) begin
                chk(k == 0 ? "stall_cnt_a" : "stall_cnt_b",
                    k == 0 ? {32'd0, stall_cnt_a} : {60'd0, stall_cnt_b}, m_sc[k]);
                chk(k == 0 ? "fwd_cnt_a" : "fwd_cnt_b",
                    k == 0 ? {32'd0, fwd_cnt_a} : {60'd0, fwd_cnt_b}, m_fc[k]);
            end
        end
    endtask

    // Advance the model across the rising edge, then move off the edge.
    task automatic advance();
        longint mx;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mx = (64'd1 << CW[k]) - 1;
            if (rst) begin
                m_sc[k] = 0;
                m_fc[k] = 0;
                stall_end[k] = 0;
            end else begin
                if (!e_wpcir[k] && m_sc[k] < mx) m_sc[k]++;
                if ((e_fa != 2'd0 || e_fb != 2'd0) && !e_stall[k] && m_fc[k] < mx) m_fc[k]++;
                if (flush) stall_end[k] = 0;
                else if (!(cyc < stall_end[k]) && e_hz) stall_end[k] = cyc + LSC[k];
            end
        end
        m_wreg  = rst ? 1'b0 : ewreg;
        m_m2reg = rst ? 1'b0 : em2reg;
        m_rn    = rst ? 5'd0 : ern;
        if (rst) cnt_valid = 1;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        clr(); rst = 1;
        settle(); advance();
        rst = 0;
    endtask

    task automatic load_use(input logic [4:0] r);
        clr(); ewreg = 1; em2reg = 1; ern = r; rs = r; use_rs = 1;
    endtask

    initial begin
        m_wreg = 0; m_m2reg = 0; m_rn = 0;
        e_hz = 0; e_fa = 0; e_fb = 0;
        e_stall = '{0, 0}; e_wpcir = '{1, 1};

        // Reset: forced outputs while rst is high, cleared counters afterwards.
        clr(); rst = 1;
        settle();
        chk("rst_fwda", {62'd0, fwda_a}, 64'd0);
        chk("rst_wpcir", {63'd0, wpcir_a}, 64'd1);
        chk("rst_bubble", {63'd0, bubble_a}, 64'd0);
        advance();
        rst = 0;
        settle();
        chk("rst_stall_cnt", {32'd0, stall_cnt_a}, 64'd0);
        chk("rst_fwd_cnt", {32'd0, fwd_cnt_a}, 64'd0);
        advance();

        // EXE ALU forward on rs.
        clr(); ewreg = 1; ern = 8; rs = 8; use_rs = 1;
        settle();
        chk("exe_fwda", {62'd0, fwda_a}, 64'd1);
        chk("exe_fwdb", {62'd0, fwdb_a}, 64'd0);
        chk("exe_wpcir", {63'd0, wpcir_a}, 64'd1);
        chk("exe_bubble", {63'd0, bubble_a}, 64'd0);
        advance();
        clr();
        settle();
        chk("exe_fwd_cnt", {32'd0, fwd_cnt_a}, 64'd1);
        advance();

        // MEM forward of load data, then of an ALU result.
        clr(); ewreg = 1; em2reg = 1; ern = 9;
        settle(); advance();
        clr(); rt = 9; use_rt = 1;
        settle();
        chk("mem_ld_fwdb", {62'd0, fwdb_a}, 64'd3);
        advance();
        clr(); ewreg = 1; ern = 9;
        settle(); advance();
        clr(); rt = 9; use_rt = 1;
        settle();
        chk("mem_alu_fwdb", {62'd0, fwdb_a}, 64'd2);
        advance();

        // Load-use: 1-cycle hold on dut_a, 3-cycle hold on dut_b.
        do_reset();
        load_use(5);
        settle();
        chk("lu_wpcir_a0", {63'd0, wpcir_a}, 64'd0);
        chk("lu_bubble_a0", {63'd0, bubble_a}, 64'd1);
        chk("lu_wpcir_b0", {63'd0, wpcir_b}, 64'd0);
        advance();
        clr(); rs = 5; use_rs = 1;
        settle();
        chk("lu_fwda_a1", {62'd0, fwda_a}, 64'd3);
        chk("lu_wpcir_a1", {63'd0, wpcir_a}, 64'd1);
        chk("lu_stall_cnt_a", {32'd0, stall_cnt_a}, 64'd1);
        chk("lu_wpcir_b1", {63'd0, wpcir_b}, 64'd0);
        advance();
        settle();
        chk("lu_wpcir_b2", {63'd0, wpcir_b}, 64'd0);
        advance();
        settle();
        chk("lu_wpcir_b3", {63'd0, wpcir_b}, 64'd1);
        chk("lu_stall_cnt_b", {60'd0, stall_cnt_b}, 64'd3);
        advance();

        // Register 0 is never forwarded and never stalls.
        clr(); ewreg = 1; em2reg = 1; ern = 0; rs = 0; use_rs = 1;
        settle();
        chk("r0_fwda", {62'd0, fwda_a}, 64'd0);
        chk("r0_wpcir", {63'd0, wpcir_b}, 64'd1);
        advance();

        // EXE and MEM both match: EXE wins.
        clr(); ewreg = 1; ern = 4;
        settle(); advance();
        clr(); ewreg = 1; ern = 4; rs = 4; use_rs = 1;
        settle();
        chk("prio_fwda", {62'd0, fwda_a}, 64'd1);
        advance();

        // Flush in the hazard cycle squashes the hold.
        do_reset();
        load_use(6); flush = 1;
        settle();
        chk("flush_bubble", {63'd0, bubble_b}, 64'd1);
        chk("flush_wpcir", {63'd0, wpcir_b}, 64'd1);
        advance();
        clr();
        settle();
        chk("flush_after_wpcir", {63'd0, wpcir_b}, 64'd1);
        advance();

        // Reset in the middle of a 3-cycle hold.
        load_use(7);
        settle(); advance();
        clr();
        settle();
        chk("midrst_hold", {63'd0, wpcir_b}, 64'd0);
        advance();
        rst = 1;
        settle(); advance();
        rst = 0;
        settle();
        chk("midrst_release", {63'd0, wpcir_b}, 64'd1);
        advance();

        // Saturation of the 4-bit forward counter.
        do_reset();
        clr(); ewreg = 1; ern = 8; rs = 8; use_rs = 1;
        for (int i = 0; i < 20; i++) begin
            settle(); advance();
        end
        settle();
        chk("sat_fwd_cnt_b", {60'd0, fwd_cnt_b}, 64'd15);
        chk("sat_fwd_cnt_a", {32'd0, fwd_cnt_a}, 64'd20);
        advance();
        settle();
        chk("sat_hold_b", {60'd0, fwd_cnt_b}, 64'd15);
        advance();

        // Random traffic on a small register window to provoke matches.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            rs     = 5'($urandom_range(0, 7));
            rt     = 5'($urandom_range(0, 7));
            ern    = 5'($urandom_range(0, 7));
            use_rs = 1'($urandom);
            use_rt = 1'($urandom);
            ewreg  = ($urandom_range(0, 3) != 0);
            em2reg = 1'($urandom);
            settle(); advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
